// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_mul_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OpNop = 2'b00,
      OpAdd = 2'b01,
      OpSub = 2'b10
   } booth_op_e;

   // Ceiling log2, used to size the iteration counter.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
      unique case ({q0, q_m1})
         2'b01:   return OpAdd;
         2'b10:   return OpSub;
         default: return OpNop;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/subtract of M into A, then arithmetic
// shift right of {A, Q, q_m1} by one bit.
module booth_step
   import booth_mul_pkg::*;
#(
   parameter int unsigned W = 17
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] mq,
   input  logic         q_m1,
   input  logic [W-1:0] m,
   output logic [W-1:0] acc_next,
   output logic [W-1:0] mq_next,
   output logic         q_m1_next
);

   booth_op_e    op;
   logic [W-1:0] sum;

   always_comb begin
      op  = booth_decode(mq[0], q_m1);
      sum = acc;
      unique case (op)
         OpAdd:   sum = acc + m;
         OpSub:   sum = acc - m;
         default: sum = acc;
      endcase
      acc_next  = {sum[W-1], sum[W-1:1]};
      mq_next   = {sum[0], mq[W-1:1]};
      q_m1_next = mq[0];
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned WIDTH-bit operands,
// one iteration per clock, start/busy/done handshake.
module booth_mul_seq
   import booth_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned W    = WIDTH + 1;
   localparam int unsigned CntW = clog2(WIDTH + 2);

   state_e              state_q, state_d;
   logic [W-1:0]        acc_q, acc_d;
   logic [W-1:0]        mq_q, mq_d;
   logic [W-1:0]        m_q, m_d;
   logic                qm1_q, qm1_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  product_q, product_d;

   logic [W-1:0]        acc_step;
   logic [W-1:0]        mq_step;
   logic                qm1_step;

   booth_step #(
      .W (W)
   ) u_step (
      .acc       (acc_q),
      .mq        (mq_q),
      .q_m1      (qm1_q),
      .m         (m_q),
      .acc_next  (acc_step),
      .mq_next   (mq_step),
      .q_m1_next (qm1_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         mq_q      <= '0;
         m_q       <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         m_q       <= m_d;
         qm1_q     <= qm1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      m_d       = m_q;
      qm1_d     = qm1_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               // One extra operand bit keeps unsigned values positive and keeps
               // M away from the most-negative value, so add/sub never overflows.
               m_d     = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
               mq_d    = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = CntW'(WIDTH + 1);
               state_d = StRun;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d = acc_step;
            mq_d  = mq_step;
            qm1_d = qm1_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               product_d = {acc_step[WIDTH-2:0], mq_step};
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign product = product_q;

endmodule
